// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet feature-map datapath stages.
package lenet_pkg;

    localparam int unsigned FM2_CH    = 2;
    localparam int unsigned FM2_DIM   = 10;
    localparam int unsigned FM2_WORDS = FM2_CH * FM2_DIM * FM2_DIM;

    typedef enum logic {IDLE, STREAM} drain_state_t;

endpackage

// File: rtl/fmap_raster_counter.sv
// Channel/row/column raster counter: column fastest, then row, then channel.
// Wraps back to all-zero after the final position.
module fmap_raster_counter #(
    parameter int unsigned NumCh = 2,
    parameter int unsigned Dim   = 10,
    parameter int unsigned ChW   = (NumCh > 1) ? $clog2(NumCh) : 1,
    parameter int unsigned DimW  = (Dim > 1) ? $clog2(Dim) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            advance,
    output logic [ChW-1:0]  ch,
    output logic [DimW-1:0] row,
    output logic [DimW-1:0] col,
    output logic            at_end
);

    logic [ChW-1:0]  ch_q, ch_d;
    logic [DimW-1:0] row_q, row_d;
    logic [DimW-1:0] col_q, col_d;
    logic            col_max, row_max, ch_max;

    assign col_max = (col_q == DimW'(Dim - 1));
    assign row_max = (row_q == DimW'(Dim - 1));
    assign ch_max  = (ch_q == ChW'(NumCh - 1));

    always_comb begin
        ch_d  = ch_q;
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            ch_d  = '0;
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_max) begin
                col_d = '0;
                if (row_max) begin
                    row_d = '0;
                    ch_d  = ch_max ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            ch_q  <= ch_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign ch     = ch_q;
    assign row    = row_q;
    assign col    = col_q;
    assign at_end = ch_max & row_max & col_max;

endmodule

// File: rtl/fmap2_stream_out.sv
// Snapshots the conv-layer-2 feature map on start and drains it word by word
// over a valid/ready stream in channel-major raster order.
module fmap2_stream_out
    import lenet_pkg::*;
#(
    parameter int unsigned bitwidth = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [FM2_CH-1:0][FM2_DIM-1:0][FM2_DIM-1:0][bitwidth-1:0] featuremap2,
    output logic                busy,
    output logic [bitwidth-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                out_ch,
    output logic [3:0]          out_row,
    output logic [3:0]          out_col,
    output logic                done
);

    drain_state_t state_q, state_d;
    logic         done_q, done_d;
    logic         capture;
    logic         advance;
    logic         at_end;

    logic [FM2_CH-1:0][FM2_DIM-1:0][FM2_DIM-1:0][bitwidth-1:0] snap_q;

    fmap_raster_counter #(
        .NumCh (FM2_CH),
        .Dim   (FM2_DIM),
        .ChW   (1),
        .DimW  (4)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (capture),
        .advance (advance),
        .ch      (out_ch),
        .row     (out_row),
        .col     (out_col),
        .at_end  (at_end)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    advance = 1'b1;
                    if (at_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Only the IDLE->STREAM transition writes the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (capture) begin
            snap_q <= featuremap2;
        end
    end

    assign busy      = (state_q == STREAM);
    assign out_valid = busy;
    assign out_last  = busy & at_end;
    assign out_data  = busy ? snap_q[out_ch][out_row][out_col] : '0;
    assign done      = done_q;

endmodule

// File: tb/tb_fmap2_stream_out.sv
// Scoreboard bench for fmap2_stream_out: stimulus pushes expected words, a negedge
// monitor pops and compares on every handshake and checks stalls and done.
module tb_fmap2_stream_out;

    logic                              clk;
    logic                              rst_n;
    logic                              start;
    logic [1:0][9:0][9:0][31:0]        fm;
    logic                              busy;
    logic [31:0]                       out_data;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;
    logic                              out_ch;
    logic [3:0]                        out_row;
    logic [3:0]                        out_col;
    logic                              done;

    fmap2_stream_out #(
        .bitwidth (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .featuremap2 (fm),
        .busy        (busy),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_ch      (out_ch),
        .out_row     (out_row),
        .out_col     (out_col),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          c;
        int          r;
        int          k;
        bit          last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: word i of a frame is fm[i/100][(i/10)%10][i%10]
    task automatic push_frame();
        for (int i = 0; i < 200; i++) begin
            exp_t e;
            e.c    = i / 100;
            e.r    = (i / 10) % 10;
            e.k    = i % 10;
            e.d    = fm[e.c][e.r][e.k];
            e.last = (i == 199);
            q.push_back(e);
        end
    endtask

    task automatic fill(input bit rnd, input int off);
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 10; r++)
                for (int k = 0; k < 10; k++)
                    fm[c][r][k] = rnd ? $urandom : 32'(c * 1000 + r * 10 + k + off);
    endtask

    // Drive start for one edge and queue the expected frame.
    task automatic kick();
        push_frame();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("valid_after_start", 64'(out_valid), 64'd1);
    endtask

    // mode 0: ready high; 1: ready 1,0,0 cyclic; 2: random ready.
    task automatic run_stream(input int mode, input bit poke_start);
        int cycles = 0;
        int stalls = 0;
        int hs     = 0;
        int guard  = 0;
        bit r;
        while (guard < 3000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cycles % 3 == 0);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            out_ready = r;
            start     = poke_start && (hs == 50);
            if (busy) begin
                cycles++;
                if (r) hs++;
                else stalls++;
            end
            @(posedge clk);
            #1;
            guard++;
            if (done) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: got no done expected done within 3000 cycles");
        end
        chk("handshakes", 64'(hs), 64'd200);
        chk("stream_cycles", 64'(cycles), 64'(200 + stalls));
    endtask

    bit          expect_done = 1'b0;
    bit          stall_v     = 1'b0;
    logic [31:0] stall_d;
    logic [9:0]  stall_idx;
    bit          stall_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            expect_done = 1'b0;
            stall_v     = 1'b0;
        end else begin
            if (expect_done) begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("busy_in_done", 64'(busy), 64'd0);
                chk("valid_in_done", 64'(out_valid), 64'd0);
                expect_done = 1'b0;
            end else if (done) begin
                chk("spurious_done", 64'(done), 64'd0);
            end
            if (stall_v && out_valid) begin
                chk("stall_data", 64'(out_data), 64'(stall_d));
                chk("stall_idx", 64'({out_ch, out_row, out_col}), 64'(stall_idx));
                chk("stall_last", 64'(out_last), 64'(stall_last));
            end
            stall_v = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(out_data), 64'hffff_ffff_ffff_ffff);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", 64'(out_data), 64'(e.d));
                    chk("index", 64'({out_ch, out_row, out_col}),
                        64'({e.c[0], e.r[3:0], e.k[3:0]}));
                    chk("last", 64'(out_last), 64'(e.last));
                    if (e.last) expect_done = 1'b1;
                end
            end else if (out_valid) begin
                stall_v    = 1'b1;
                stall_d    = out_data;
                stall_idx  = {out_ch, out_row, out_col};
                stall_last = out_last;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        fm        = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_idx", 64'({out_ch, out_row, out_col}), 64'd0);
        chk("rst_last_done", 64'({out_last, done}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic order with ready held high
        fill(1'b0, 0);
        kick();
        chk("first_word", 64'(out_data), 64'd0);
        run_stream(0, 1'b0);

        // Backpressure 1,0,0 with the same data
        repeat (2) @(posedge clk);
        #1;
        kick();
        run_stream(1, 1'b0);

        // Random data, random ready, input overwritten, start poked mid-stream
        repeat (2) @(posedge clk);
        #1;
        fill(1'b1, 0);
        kick();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 10; r++)
                for (int k = 0; k < 10; k++)
                    fm[c][r][k] = 32'hDEAD_BEEF;
        run_stream(2, 1'b1);

        // Back-to-back: start in the done cycle with +5000 data
        repeat (2) @(posedge clk);
        #1;
        fill(1'b0, 0);
        kick();
        run_stream(0, 1'b0);
        fill(1'b0, 5000);
        kick();
        chk("b2b_first_word", 64'(out_data), 64'd5000);
        run_stream(2, 1'b0);

        // Reset mid-stream at word 120
        repeat (2) @(posedge clk);
        #1;
        fill(1'b1, 0);
        kick();
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_busy_last", 64'({busy, out_last, done}), 64'd0);
        chk("mid_rst_idx", 64'({out_ch, out_row, out_col}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_done", 64'(done), 64'd0);
        fill(1'b1, 0);
        kick();
        chk("restart_idx", 64'({out_ch, out_row, out_col}), 64'd0);
        run_stream(0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
